// File: rtl/jtsdram_pkg.sv
// Shared address-shuffle and data-scramble helpers for the SDRAM test core.
// Both the writer and the read-back checker use these so the two ends agree.
package jtsdram_pkg;

  localparam logic [21:0] ADDR_XOR_K3 = 22'h155555;
  localparam logic [21:0] ADDR_XOR_K4 = 22'h2AAAAA;
  localparam logic [15:0] DATA_XOR_K3 = 16'h5555;
  localparam logic [15:0] DATA_XOR_K4 = 16'hAAAA;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CHECK
  } state_t;

  // Nibble bit permutation used by both the address and data scrambles.
  function automatic logic [3:0] swap(input logic [3:0] n);
    return {n[2], n[0], n[3], n[1]};
  endfunction

  // Linear -> physical address, each key bit enabling one step, applied in order.
  function automatic logic [21:0] shuffle_addr(input logic [4:0] key, input logic [21:0] a);
    logic [21:0] r;
    r = a;
    if (key[0]) r = {r[11:0], r[12], r[21:13]};
    if (key[1]) r = {r[21:12], swap(r[11:8]), swap(r[7:4]), swap(r[3:0])};
    if (key[2]) r = {r[20], r[21], swap(r[19:16]), swap(r[15:12]), r[11:0]};
    if (key[3]) r = r ^ ADDR_XOR_K3;
    if (key[4]) r = r ^ ADDR_XOR_K4;
    return r;
  endfunction

  // Reference word scramble; sel is the low nibble of the physical address.
  function automatic logic [15:0] scramble_data(input logic [4:0] key, input logic [3:0] sel,
                                                input logic [15:0] d);
    logic [15:0] r;
    r = d;
    if (key[0] ^ sel[0]) r = {r[7:0], r[15:8]};
    if (key[1] ^ sel[1]) r = {r[15:8], swap(r[7:4]), swap(r[3:0])};
    if (key[2] ^ sel[2]) r = {swap(r[15:12]), swap(r[11:8]), r[7:0]};
    if (key[3] ^ sel[3]) r = r ^ DATA_XOR_K3;
    if (key[4])          r = r ^ DATA_XOR_K4;
    return r;
  endfunction

endpackage

// File: rtl/jtsdram_verify_expect.sv
// Registered stage turning the current linear address into the physical
// read address and the expected reference word, updated during ISSUE.
module jtsdram_expect
  import jtsdram_pkg::*;
#(
  parameter logic [15:0] SEED = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic [4:0]  key_i,
  input  logic [21:0] lin_i,
  output logic [21:0] phys_o,
  output logic [15:0] exp_o
);

  logic [21:0] phys_d, phys_q;
  logic [15:0] exp_d, exp_q;

  always_comb begin
    phys_d = shuffle_addr(key_i, lin_i);
    exp_d  = scramble_data(key_i, phys_d[3:0], lin_i[15:0] ^ SEED);
  end

  // Physical address is a visible port, so it clears on reset; the reference word does not need to.
  always_ff @(posedge clk) begin
    if (rst) begin
      phys_q <= '0;
    end else if (en_i) begin
      phys_q <= phys_d;
    end
    if (en_i) exp_q <= exp_d;
  end

  assign phys_o = phys_q;
  assign exp_o  = exp_q;

endmodule

// File: rtl/jtsdram_verify.sv
// SDRAM read-back checker: sweeps linear addresses, reads each shuffled
// physical address and compares against the regenerated reference word.
module jtsdram_verify
  import jtsdram_pkg::*;
#(
  parameter logic [15:0] SEED    = 16'h0000,
  parameter int          TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  key,
  input  logic [21:0] addr_max,
  output logic [21:0] sdram_addr,
  output logic        sdram_rd,
  input  logic        data_ok,
  input  logic [15:0] sdram_dout,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [15:0] err_cnt,
  output logic [21:0] first_bad_addr,
  output logic [15:0] first_bad_data
);

  // Abort on the last permitted WAIT cycle (timer counts from 0).
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

  state_t      state_d, state_q;
  logic [4:0]  key_d, key_q;
  logic [21:0] amax_d, amax_q;
  logic [21:0] lin_d, lin_q;
  logic [9:0]  timer_d, timer_q;
  logic        rd_d, rd_q;
  logic        busy_d, busy_q;
  logic        done_d, done_q;
  logic        to_d, to_q;
  logic [15:0] err_d, err_q;
  logic [21:0] fba_d, fba_q;
  logic [15:0] fbd_d, fbd_q;
  logic [15:0] dout_d, dout_q;
  logic [15:0] exp_w;

  jtsdram_expect #(.SEED(SEED)) u_expect (
    .clk    (clk),
    .rst    (rst),
    .en_i   (state_q == ST_ISSUE),
    .key_i  (key_q),
    .lin_i  (lin_q),
    .phys_o (sdram_addr),
    .exp_o  (exp_w)
  );

  // Next-state and output decode for the sweep sequencer.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    amax_d  = amax_q;
    lin_d   = lin_q;
    timer_d = timer_q;
    rd_d    = rd_q;
    busy_d  = busy_q;
    done_d  = done_q;
    to_d    = to_q;
    err_d   = err_q;
    fba_d   = fba_q;
    fbd_d   = fbd_q;
    dout_d  = dout_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          key_d   = key;
          amax_d  = addr_max;
          err_d   = '0;
          fba_d   = '0;
          fbd_d   = '0;
          done_d  = 1'b0;
          to_d    = 1'b0;
          lin_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        rd_d    = 1'b1;
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (data_ok) begin
          rd_d    = 1'b0;
          dout_d  = sdram_dout;
          state_d = ST_CHECK;
        end else if (timer_q == TMO_LAST) begin
          rd_d    = 1'b0;
          to_d    = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + 10'd1;
        end
      end
      ST_CHECK: begin
        if (dout_q != exp_w) begin
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          if (err_q == 16'd0) begin
            fba_d = lin_q;
            fbd_d = dout_q;
          end
        end
        // Compare before incrementing so addr_max = 3FFFFF never wraps lin.
        if (lin_q == amax_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          lin_d   = lin_q + 22'd1;
          state_d = ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and status registers; captured read data is not reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      amax_q  <= '0;
      lin_q   <= '0;
      timer_q <= '0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      err_q   <= '0;
      fba_q   <= '0;
      fbd_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      amax_q  <= amax_d;
      lin_q   <= lin_d;
      timer_q <= timer_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      to_q    <= to_d;
      err_q   <= err_d;
      fba_q   <= fba_d;
      fbd_q   <= fbd_d;
    end
    dout_q <= dout_d;
  end

  assign sdram_rd       = rd_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign timeout        = to_q;
  assign err_cnt        = err_q;
  assign first_bad_addr = fba_q;
  assign first_bad_data = fbd_q;

endmodule
